// File: rtl/sequential_to_simultaneous_reg.sv
// Serial-in, parallel-out symbol collector: gathers SHIFT_LEN symbols, one per
// CLK_DISTANCE qualified strobes, and presents them as one word with a valid pulse.
module sequential_to_simultaneous_reg #(
   parameter int DIRECTION    = 1,
   parameter int SHIFT_LEN    = 1,
   parameter int BIT_WIDTH    = 2,
   parameter int CLK_DISTANCE = 1
) (
   input  logic                           clk,
   input  logic                           in_ctr_Srst,
   input  logic                           in_ctr_init,
   input  logic                           in_ctr_en,
   input  logic                           in_ctr_sft_en,
   input  logic [BIT_WIDTH-1:0]           in,
   output logic [BIT_WIDTH*SHIFT_LEN-1:0] out,
   output logic                           out_valid,
   output logic                           out_busy
);

   generate
      if (SHIFT_LEN <= 0) begin : g_empty
         $warning("sequential_to_simultaneous_reg: SHIFT_LEN must be >= 1, outputs tied to 0");
         assign out       = '0;
         assign out_valid = 1'b0;
         assign out_busy  = 1'b0;
      end else begin : g_core
         localparam int DIST   = (CLK_DISTANCE < 1) ? 1 : CLK_DISTANCE;
         localparam int DCNT_W = (DIST > 1) ? $clog2(DIST) : 1;
         localparam int SCNT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
         localparam int WORD_W = BIT_WIDTH * SHIFT_LEN;
         localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIST - 1);
         localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SHIFT_LEN - 1);

         logic [DCNT_W-1:0] dcnt_q, dcnt_d;
         logic [SCNT_W-1:0] scnt_q, scnt_d;
         logic [WORD_W-1:0] stage_q, stage_d;
         logic [WORD_W-1:0] out_q, out_d;
         logic              valid_q, valid_d;
         logic              busy_q;
         logic              strobe;
         logic              sample;
         logic [SCNT_W-1:0] slot;
         logic [WORD_W-1:0] merged;

         always_comb begin
            strobe = in_ctr_en & in_ctr_sft_en & ~in_ctr_init;
            sample = strobe & (dcnt_q == DCNT_LAST);
            slot   = (DIRECTION > 0) ? scnt_q : (SCNT_LAST - scnt_q);

            // Staging with the current symbol dropped into its slot; on the
            // final symbol this is the completed word.
            merged = stage_q;
            for (int k = 0; k < SHIFT_LEN; k++) begin
               if (slot == SCNT_W'(k)) begin
                  merged[k*BIT_WIDTH +: BIT_WIDTH] = in;
               end
            end

            dcnt_d  = dcnt_q;
            scnt_d  = scnt_q;
            stage_d = stage_q;
            out_d   = out_q;
            valid_d = 1'b0;

            if (in_ctr_en) begin
               if (in_ctr_init) begin
                  dcnt_d  = '0;
                  scnt_d  = '0;
                  stage_d = '0;
               end else if (sample) begin
                  dcnt_d = '0;
                  if (scnt_q == SCNT_LAST) begin
                     out_d   = merged;
                     valid_d = 1'b1;
                     scnt_d  = '0;
                     stage_d = '0;
                  end else begin
                     stage_d = merged;
                     scnt_d  = scnt_q + 1'b1;
                  end
               end else if (strobe) begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (in_ctr_Srst) begin
               dcnt_q  <= '0;
               scnt_q  <= '0;
               stage_q <= '0;
               out_q   <= '0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end else begin
               dcnt_q  <= dcnt_d;
               scnt_q  <= scnt_d;
               stage_q <= stage_d;
               out_q   <= out_d;
               valid_q <= valid_d;
               busy_q  <= (scnt_d != '0);
            end
         end

         assign out       = out_q;
         assign out_valid = valid_q;
         assign out_busy  = busy_q;
      end
   endgenerate

endmodule

// File: tb/tb_sequential_to_simultaneous_reg.sv
// Directed bench: vector table for DIRECTION 1/0 collectors, plus hand sequences
// for symbol spacing (CLK_DISTANCE=3) and back-to-back one-symbol words.
module tb_sequential_to_simultaneous_reg;

   logic        clk;
   logic        srst, init, en, sft;
   logic [3:0]  din;
   logic [11:0] out_a, out_b, out_c;
   logic [3:0]  out_d;
   logic        val_a, val_b, val_c, val_d;
   logic        busy_a, busy_b, busy_c, busy_d;

   int n_checks = 0;
   int n_pass   = 0;

   sequential_to_simultaneous_reg #(.DIRECTION(1), .SHIFT_LEN(3), .BIT_WIDTH(4), .CLK_DISTANCE(1)) u_a (
      .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
      .in(din), .out(out_a), .out_valid(val_a), .out_busy(busy_a));

   sequential_to_simultaneous_reg #(.DIRECTION(0), .SHIFT_LEN(3), .BIT_WIDTH(4), .CLK_DISTANCE(1)) u_b (
      .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
      .in(din), .out(out_b), .out_valid(val_b), .out_busy(busy_b));

   sequential_to_simultaneous_reg #(.DIRECTION(1), .SHIFT_LEN(3), .BIT_WIDTH(4), .CLK_DISTANCE(3)) u_c (
      .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
      .in(din), .out(out_c), .out_valid(val_c), .out_busy(busy_c));

   sequential_to_simultaneous_reg #(.DIRECTION(1), .SHIFT_LEN(1), .BIT_WIDTH(4), .CLK_DISTANCE(1)) u_d (
      .clk(clk), .in_ctr_Srst(srst), .in_ctr_init(init), .in_ctr_en(en), .in_ctr_sft_en(sft),
      .in(din), .out(out_d), .out_valid(val_d), .out_busy(busy_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        srst, init, en, sft;
      logic [3:0]  din;
      logic [11:0] exp_a;
      logic [11:0] exp_b;
      logic        exp_v;
      logic        exp_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic s, input logic i, input logic e, input logic f,
                               input logic [3:0] d, input logic [11:0] ea, input logic [11:0] eb,
                               input logic v, input logic b);
      vec_t r;
      r.srst = s; r.init = i; r.en = e; r.sft = f; r.din = d;
      r.exp_a = ea; r.exp_b = eb; r.exp_v = v; r.exp_busy = b;
      return r;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, got, exp);
      else
         n_pass++;
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic apply(input logic s, input logic i, input logic e, input logic f, input logic [3:0] d);
      srst = s; init = i; en = e; sft = f; din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      srst = 1'b0; init = 1'b0; en = 1'b0; sft = 1'b0; din = 4'h0;

      //             srst init en sft din   out_a    out_b    v  busy
      tbl.push_back(mk(1, 0, 0, 0, 4'h0, 12'h000, 12'h000, 0, 0)); // reset
      tbl.push_back(mk(0, 0, 1, 1, 4'h1, 12'h000, 12'h000, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h2, 12'h000, 12'h000, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h3, 12'h321, 12'h123, 1, 0)); // completion
      tbl.push_back(mk(0, 0, 1, 0, 4'h0, 12'h321, 12'h123, 0, 0)); // single pulse
      tbl.push_back(mk(0, 0, 1, 1, 4'h4, 12'h321, 12'h123, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h5, 12'h321, 12'h123, 0, 1));
      tbl.push_back(mk(0, 1, 1, 1, 4'h6, 12'h321, 12'h123, 0, 0)); // init drops 6
      tbl.push_back(mk(0, 0, 1, 1, 4'hA, 12'h321, 12'h123, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'hB, 12'h321, 12'h123, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'hC, 12'hCBA, 12'hABC, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 4'h1, 12'hCBA, 12'hABC, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1, 4'hF, 12'hCBA, 12'hABC, 0, 1)); // en low: hold
      tbl.push_back(mk(0, 0, 0, 1, 4'hE, 12'hCBA, 12'hABC, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'hD, 12'hCBA, 12'hABC, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 4'hE, 12'hCBA, 12'hABC, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1, 4'hF, 12'hCBA, 12'hABC, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h2, 12'hCBA, 12'hABC, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h3, 12'h321, 12'h123, 1, 0)); // same as gap-free
      tbl.push_back(mk(0, 1, 1, 1, 4'h7, 12'h321, 12'h123, 0, 0)); // init after completion
      tbl.push_back(mk(0, 0, 1, 1, 4'h4, 12'h321, 12'h123, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h5, 12'h321, 12'h123, 0, 1));
      tbl.push_back(mk(1, 0, 1, 1, 4'h6, 12'h000, 12'h000, 0, 0)); // reset mid-word
      tbl.push_back(mk(0, 0, 1, 1, 4'h7, 12'h000, 12'h000, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h8, 12'h000, 12'h000, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'h9, 12'h987, 12'h789, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 4'h0, 12'h987, 12'h789, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].srst, tbl[i].init, tbl[i].en, tbl[i].sft, tbl[i].din);
         check("out_a",  i, 32'(out_a),  32'(tbl[i].exp_a));
         check("val_a",  i, 32'(val_a),  32'(tbl[i].exp_v));
         check("busy_a", i, 32'(busy_a), 32'(tbl[i].exp_busy));
         check("out_b",  i, 32'(out_b),  32'(tbl[i].exp_b));
         check("val_b",  i, 32'(val_b),  32'(tbl[i].exp_v));
         check("busy_b", i, 32'(busy_b), 32'(tbl[i].exp_busy));
      end

      // Symbol spacing: with CLK_DISTANCE=3, symbols 2, 5, 8 are taken.
      // The one-symbol collector completes a word on every strobe.
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      check("rst_out_c", 0, 32'(out_c), 32'h0);
      check("rst_out_d", 0, 32'(out_d), 32'h0);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         apply(1'b0, 1'b0, 1'b1, 1'b1, 4'(i));
         if (val_c) pulses++;
         check("out_c",  i, 32'(out_c),  (i == 8) ? 32'h852 : 32'h0);
         check("val_c",  i, 32'(val_c),  (i == 8) ? 32'h1 : 32'h0);
         check("busy_c", i, 32'(busy_c), (i >= 2 && i < 8) ? 32'h1 : 32'h0);
         check("out_d",  i, 32'(out_d),  32'(i));
         check("val_d",  i, 32'(val_d),  32'h1);
         check("busy_d", i, 32'(busy_d), 32'h0);
      end
      apply(1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
      check("val_c_idle", 9, 32'(val_c), 32'h0);
      check("out_c_hold", 9, 32'(out_c), 32'h852);
      check("pulses_c",   9, 32'(pulses), 32'h1);
      check("val_d_idle", 9, 32'(val_d), 32'h0);
      check("out_d_hold", 9, 32'(out_d), 32'h8);

      // Init clears the distance counter: after it, three more strobes are needed.
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
      apply(1'b0, 1'b1, 1'b1, 1'b1, 4'h2);
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'h4);
      check("busy_c_init", 10, 32'(busy_c), 32'h0);
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
      check("busy_c_samp", 11, 32'(busy_c), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
